line_option_generator: RTL and testbench

- Producer end of the solver's option FIFO.
- For one line (row or column), takes the line index and its clue list.
- Emits a framed stream into the FIFO write port:
  - first an index word carrying the line index,
  - then every legal placement of the clue blocks, one SIZE-bit option per word.
- Reports the final option count so the top level can write the per-line options-amount BRAM entry the solver reads back.

---
 rtl/line_option_generator_if.sv | 12 +
 rtl/line_option_generator.sv | 203 ++++++++++++++++++++
 tb/tb_line_option_generator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_option_generator_if.sv
// rtl/line_option_generator_if.sv - option FIFO write-port stream between the generator and the FIFO
interface line_option_generator_if #(
    parameter int SIZE = 3
);
    logic [SIZE-1:0] tdata;
    logic            tis_index;
    logic            tvalid;
    logic            tready;

    modport master (output tdata, output tis_index, output tvalid, input tready);
    modport slave  (input tdata, input tis_index, input tvalid, output tready);
endinterface

// File: rtl/line_option_generator.sv
// rtl/line_option_generator.sv - enumerates every legal block placement of one line into the option FIFO
module line_option_generator #(
    parameter int SIZE       = 3,
    parameter int MAX_CLUES  = 2,
    parameter int CNT_W      = 7,
    localparam int IW        = $clog2(2 * SIZE),
    localparam int NW        = $clog2(MAX_CLUES + 1),
    localparam int LW        = $clog2(SIZE + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [IW-1:0]                line_ind_i,
    input  logic [NW-1:0]                num_clues_i,
    input  logic [MAX_CLUES-1:0][LW-1:0] clue_lens_i,
    line_option_generator_if.master      out_if,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             opt_count_o,
    output logic                         infeasible_o,
    output logic                         overflow_o
);
    // Wide enough for any block position plus a full suffix width without wrapping.
    localparam int SW = LW + NW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_IDX,
        S_OPT,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [IW-1:0]                ind_q, ind_d;
    logic [NW-1:0]                nc_q, nc_d;
    logic [MAX_CLUES-1:0][LW-1:0] len_q, len_d;
    logic [SW-1:0]                pos_q [MAX_CLUES];
    logic [SW-1:0]                pos_d [MAX_CLUES];
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         inf_q, inf_d;
    logic                         ovf_q, ovf_d;

    logic [SW-1:0]                suf [MAX_CLUES];
    logic [SW-1:0]                left_pos [MAX_CLUES];
    logic [SW-1:0]                adv_pos [MAX_CLUES];
    logic                         adv_found;
    int                           adv_k;
    logic                         bad_clue;
    logic [SIZE-1:0]              opt_mask;

    // suf[k] = width of blocks k.. packed leftmost, each counted with one trailing gap.
    always_comb begin
        for (int k = 0; k < MAX_CLUES; k++) begin
            suf[k] = '0;
            for (int j = k; j < MAX_CLUES; j++) begin
                if (j < int'(nc_q)) begin
                    suf[k] = suf[k] + SW'(len_q[j]) + SW'(1);
                end
            end
        end
    end

    always_comb begin
        left_pos[0] = '0;
        for (int k = 1; k < MAX_CLUES; k++) begin
            left_pos[k] = left_pos[k-1] + SW'(len_q[k-1]) + SW'(1);
        end
        bad_clue = (int'(nc_q) > MAX_CLUES) || (suf[0] > SW'(SIZE + 1));
        for (int k = 0; k < MAX_CLUES; k++) begin
            if ((k < int'(nc_q)) && (len_q[k] == '0)) begin
                bad_clue = 1'b1;
            end
        end
    end

    // Block k may step right iff it plus everything after it, repacked, still ends inside the line.
    always_comb begin
        adv_found = 1'b0;
        adv_k     = 0;
        for (int k = 0; k < MAX_CLUES; k++) begin
            if ((k < int'(nc_q)) && (pos_q[k] + suf[k] <= SW'(SIZE))) begin
                adv_found = 1'b1;
                adv_k     = k;
            end
        end
        for (int k = 0; k < MAX_CLUES; k++) begin
            adv_pos[k] = (adv_found && (k == adv_k)) ? pos_q[k] + SW'(1) : pos_q[k];
        end
        for (int k = 1; k < MAX_CLUES; k++) begin
            if (adv_found && (k > adv_k)) begin
                adv_pos[k] = adv_pos[k-1] + SW'(len_q[k-1]) + SW'(1);
            end
        end
    end

    always_comb begin
        opt_mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            for (int k = 0; k < MAX_CLUES; k++) begin
                if ((k < int'(nc_q)) && (SW'(i) >= pos_q[k]) &&
                    (SW'(i) < pos_q[k] + SW'(len_q[k]))) begin
                    opt_mask[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ind_q   <= '0;
            nc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            inf_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < MAX_CLUES; k++) begin
                pos_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ind_q   <= ind_d;
            nc_q    <= nc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            inf_q   <= inf_d;
            ovf_q   <= ovf_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ind_d   = ind_q;
        nc_d    = nc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        inf_d   = inf_q;
        ovf_d   = ovf_q;
        pos_d   = pos_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ind_d   = line_ind_i;
                    nc_d    = num_clues_i;
                    len_d   = clue_lens_i;
                    cnt_d   = '0;
                    inf_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pos_d   = left_pos;
                inf_d   = bad_clue;
                state_d = S_IDX;
            end
            S_IDX: begin
                if (out_if.tready) begin
                    state_d = inf_q ? S_DONE : S_OPT;
                end
            end
            S_OPT: begin
                if (out_if.tready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!adv_found) begin
                        state_d = S_DONE;
                    end else if (cnt_d == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pos_d = adv_pos;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        out_if.tvalid    = (state_q == S_IDX) || (state_q == S_OPT);
        out_if.tis_index = (state_q == S_IDX);
        out_if.tdata     = '0;
        if (state_q == S_IDX) begin
            out_if.tdata = SIZE'(ind_q);
        end else if (state_q == S_OPT) begin
            out_if.tdata = opt_mask;
        end
    end

    assign busy_o       = (state_q == S_LOAD) || (state_q == S_IDX) || (state_q == S_OPT);
    assign done_o       = (state_q == S_DONE);
    assign opt_count_o  = cnt_q;
    assign infeasible_o = inf_q;
    assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_line_option_generator.sv
// tb/tb_line_option_generator.sv - table-driven scoreboard bench for line_option_generator
module tb_line_option_generator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start, sel, ready;
    logic             start5, start3;
    logic [3:0]       ind;
    logic [1:0]       nc;
    logic [2:0][2:0]  clue5;
    logic [1:0][1:0]  clue3;
    logic             busy5, done5, inf5, ovf5;
    logic [6:0]       cnt5;
    logic             busy3, done3, inf3, ovf3;
    logic [0:0]       cnt3;

    logic [4:0]       m_data;
    logic             m_valid, m_is_index, m_busy, m_done, m_inf, m_ovf;
    logic [6:0]       m_cnt;

    line_option_generator_if #(.SIZE(5)) if5 ();
    line_option_generator_if #(.SIZE(3)) if3 ();

    assign start5    = start && !sel;
    assign start3    = start && sel;
    assign if5.tready = ready;
    assign if3.tready = ready;

    line_option_generator #(.SIZE(5), .MAX_CLUES(3), .CNT_W(7)) dut5 (
        .clk(clk), .rst_n(rst_n), .start_i(start5), .line_ind_i(ind),
        .num_clues_i(nc), .clue_lens_i(clue5), .out_if(if5),
        .busy_o(busy5), .done_o(done5), .opt_count_o(cnt5),
        .infeasible_o(inf5), .overflow_o(ovf5)
    );

    line_option_generator #(.SIZE(3), .MAX_CLUES(2), .CNT_W(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3), .line_ind_i(ind[2:0]),
        .num_clues_i(nc), .clue_lens_i(clue3), .out_if(if3),
        .busy_o(busy3), .done_o(done3), .opt_count_o(cnt3),
        .infeasible_o(inf3), .overflow_o(ovf3)
    );

    always_comb begin
        if (!sel) begin
            m_data = if5.tdata; m_valid = if5.tvalid; m_is_index = if5.tis_index;
            m_busy = busy5; m_done = done5; m_inf = inf5; m_ovf = ovf5; m_cnt = cnt5;
        end else begin
            m_data = {2'b00, if3.tdata}; m_valid = if3.tvalid; m_is_index = if3.tis_index;
            m_busy = busy3; m_done = done3; m_inf = inf3; m_ovf = ovf3; m_cnt = {6'd0, cnt3};
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       is_index;
        logic [4:0] data;
    } word_t;

    word_t expq[$];

    typedef struct {
        string      name;
        int         dut;
        int         ind;
        int         nc;
        int         l0, l1, l2;
        int         nexp;
        logic [4:0] w0, w1, w2;
        int         cnt;
        bit         inf;
        bit         ovf;
        int         mode;
        bit         poke;
    } vec_t;

    function automatic vec_t mk(input string name, input int dut, input int ind_v, input int nc_v,
                                input int l0, input int l1, input int l2, input int nexp,
                                input logic [4:0] w0, input logic [4:0] w1, input logic [4:0] w2,
                                input int cnt, input bit inf, input bit ovf,
                                input int mode, input bit poke);
        vec_t v;
        v.name = name; v.dut = dut; v.ind = ind_v; v.nc = nc_v;
        v.l0 = l0; v.l1 = l1; v.l2 = l2; v.nexp = nexp;
        v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.cnt = cnt; v.inf = inf; v.ovf = ovf; v.mode = mode; v.poke = poke;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int         cyc;
        bit         stalled;
        word_t      held, e;
        logic [4:0] ws[3];
        logic [5:0] pat;
        pat   = 6'b101001;
        sel   = (v.dut != 0);
        ws[0] = v.w0; ws[1] = v.w1; ws[2] = v.w2;
        expq.delete();
        expq.push_back({1'b1, 5'(v.ind)});
        for (int i = 0; i < v.nexp; i++) expq.push_back({1'b0, ws[i]});

        @(negedge clk);
        ind = 4'(v.ind); nc = 2'(v.nc);
        clue5[0] = 3'(v.l0); clue5[1] = 3'(v.l1); clue5[2] = 3'(v.l2);
        clue3[0] = 2'(v.l0); clue3[1] = 2'(v.l1);
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({v.name, " busy_after_start"}, int'(m_busy), 1);
        check({v.name, " no_valid_in_load"}, int'(m_valid), 0);

        cyc = 0; stalled = 1'b0; held = '0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            case (v.mode)
                0:       ready = 1'b1;
                1:       ready = pat[(cyc - 1) % 6];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            start = v.poke && (cyc == 3);
            if (start) begin
                ind = 4'd1; nc = 2'd1; clue5[0] = 3'd1; clue3[0] = 2'd1;
            end
            #1;
            if (m_done) break;
            if (cyc == 1) check({v.name, " first_valid_latency"}, int'(m_valid), 1);
            if (stalled) begin
                check({v.name, " valid_held"}, int'(m_valid), 1);
                check({v.name, " word_held"}, int'({m_is_index, m_data}), int'(held));
            end
            if (m_valid && ready) begin
                if (expq.size() == 0) begin
                    check({v.name, " extra_word"}, int'({m_is_index, m_data}), -1);
                end else begin
                    e = expq.pop_front();
                    check({v.name, " word_data"}, int'(m_data), int'(e.data));
                    check({v.name, " word_is_index"}, int'(m_is_index), int'(e.is_index));
                end
            end
            stalled = m_valid && !ready;
            held    = {m_is_index, m_data};
        end
        start = 1'b0;
        check({v.name, " done_reached"}, int'(m_done), 1);
        check({v.name, " busy_low_at_done"}, int'(m_busy), 0);
        check({v.name, " opt_count"}, int'(m_cnt), v.cnt);
        check({v.name, " infeasible"}, int'(m_inf), int'(v.inf));
        check({v.name, " overflow"}, int'(m_ovf), int'(v.ovf));
        check({v.name, " words_missing"}, expq.size(), 0);
        @(negedge clk);
        #1;
        check({v.name, " done_one_cycle"}, int'(m_done), 0);
        check({v.name, " opt_count_held"}, int'(m_cnt), v.cnt);
    endtask

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; ready = 1'b0;
        ind = '0; nc = '0; clue5 = '0; clue3 = '0;
        #12;
        check("reset valid", int'(m_valid), 0);
        check("reset is_index", int'(m_is_index), 0);
        check("reset data", int'(m_data), 0);
        check("reset busy", int'(m_busy), 0);
        check("reset done", int'(m_done), 0);
        check("reset count", int'(m_cnt), 0);
        check("reset infeasible", int'(m_inf), 0);
        check("reset overflow", int'(m_ovf), 0);
        check("reset valid small", int'(if3.tvalid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back(mk("r3",     0, 2, 1, 3, 0, 0, 3, 5'b00111, 5'b01110, 5'b11100, 3, 0, 0, 0, 0));
        vecs.push_back(mk("r12",    0, 7, 2, 1, 2, 0, 3, 5'b01101, 5'b11001, 5'b11010, 3, 0, 0, 0, 0));
        vecs.push_back(mk("r32",    0, 4, 2, 3, 2, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 0, 0));
        vecs.push_back(mk("r0",     0, 9, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 0));
        vecs.push_back(mk("r111",   0, 1, 3, 1, 1, 1, 1, 5'b10101, 5'b00000, 5'b00000, 1, 0, 0, 0, 0));
        vecs.push_back(mk("r21",    0, 0, 2, 2, 1, 0, 3, 5'b01011, 5'b10011, 5'b10110, 3, 0, 0, 2, 0));
        vecs.push_back(mk("r10",    0, 3, 2, 1, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 0, 0));
        vecs.push_back(mk("r5",     0, 5, 1, 5, 0, 0, 1, 5'b11111, 5'b00000, 5'b00000, 1, 0, 0, 0, 0));
        vecs.push_back(mk("bp3",    0, 2, 1, 3, 0, 0, 3, 5'b00111, 5'b01110, 5'b11100, 3, 0, 0, 1, 1));
        vecs.push_back(mk("s11",    1, 3, 2, 1, 1, 0, 1, 5'b00101, 5'b00000, 5'b00000, 1, 0, 0, 0, 0));
        vecs.push_back(mk("s1ovf",  1, 5, 1, 1, 0, 0, 1, 5'b00001, 5'b00000, 5'b00000, 1, 0, 1, 0, 0));
        vecs.push_back(mk("s2ovf",  1, 3, 1, 2, 0, 0, 1, 5'b00011, 5'b00000, 5'b00000, 1, 0, 1, 0, 0));
        vecs.push_back(mk("s0",     1, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted while the second option word of clue {3} is on the bus.
        sel = 1'b0;
        @(negedge clk);
        ind = 4'd2; nc = 2'd1; clue5 = '0; clue5[0] = 3'd3; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst second option data", int'(m_data), 5'b01110);
        check("rst second option valid", int'(m_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst valid drop", int'(m_valid), 0);
        check("rst busy drop", int'(m_busy), 0);
        check("rst done low", int'(m_done), 0);
        check("rst count clear", int'(m_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
